multi_freq_counter: RTL and testbench
=====================================

Name: multi_freq_counter

Overview:
- Parametrised multi-channel successor to the single-channel frequency counter feeding the AXI result path.
- Measures edge counts on CHANNELS asynchronous pulse inputs over a common gate window of GATE_CYCLES clocks.
- At each gate end, snapshots all channels and streams them out one per handshake as (channel, count, overflow) records, for the AXI master / data_mem writer downstream.

Parameters:
- CHANNELS, 4: number of independent pulse inputs (1..16).
- GATE_CYCLES, 100_000_000: gate window length in clk cycles (>=CHANNELS+2).
- COUNT_W, 32: width of each per-channel edge counter.
- SYNC_STAGES, 2: synchroniser depth per input (>=2).
- EDGE_MODE, 0: 0 = rising, 1 = falling, 2 = both edges counted.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- enable, input, 1: run measurement; low holds gate and live counters cleared.
- pulse_in, input, CHANNELS: asynchronous pulse sources.
- res_valid, output, 1: result record available.
- res_ready, input, 1: consumer accepts record when res_valid and res_ready are both high.
- res_chan, output, $clog2(CHANNELS) (min 1): channel index of the record.
- res_count, output, COUNT_W: edge count for that channel in the completed window.
- res_ovf, output, 1: count saturated in that window.
- gate_active, output, 1: a window is currently being counted.
- gate_tick, output, 1: one-cycle pulse on the last cycle of each window.
- overrun, output, 1: sticky; a snapshot was discarded before it was fully drained.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0.
  - Synchronisers, edge registers, gate counter, live counters, shadow registers and the serialiser are cleared.
- Input path:
  - Each pulse_in[i] passes through SYNC_STAGES flops, then a previous-value register.
  - Edge detect = sync & ~prev (mode 0), ~sync & prev (mode 1), or sync ^ prev (mode 2).
  - Latency from a pin transition to a live-counter increment: SYNC_STAGES+1 cycles.
- Gate counter:
  - Runs 0..GATE_CYCLES-1 while enable=1 and wraps to 0.
  - gate_active = enable.
  - gate_tick = 1 when the count equals GATE_CYCLES-1.
- Live counters:
  - Increment on a detected edge.
  - Saturate at 2^COUNT_W-1 and set the per-channel ovf flag; no wrap.
  - An edge detected in the gate_tick cycle is counted into the closing window.
- Snapshot at gate_tick:
  - Shadow[i] takes live[i] (including that cycle's edge) and ovf[i].
  - Live counters and ovf flags clear to 0 on the following cycle boundary.
  - No edges are lost between windows.
- Serialiser FSM: IDLE -> SEND -> IDLE.
  - IDLE: on gate_tick, load ptr=0, go to SEND; res_valid rises the next cycle.
  - SEND: res_valid=1; res_chan=ptr; res_count/res_ovf = shadow[ptr].
  - On handshake: ptr increments. After ptr=CHANNELS-1 is accepted, go to IDLE and drop res_valid the next cycle.
  - res_valid holds, and the data stays stable, until accepted (AXI-stream rules); no combinational path from res_ready to res_valid.
  - Maximum throughput is one record per cycle with res_ready tied high.
- Overrun: gate_tick while in SEND (handshake in the same cycle included).
  - overrun set and stays set until reset.
  - Shadows reload and ptr restarts at 0.
  - The in-flight record is replaced; no partial mixing of windows.
- enable deasserted mid-window:
  - Gate counter and live counters clear; no snapshot, no gate_tick.
  - A serialiser already in SEND finishes draining the current snapshot.
- enable reasserted: a fresh window starts at gate count 0.
- Reset mid-operation: everything clears immediately; no record is emitted afterwards until a complete window elapses.

Test Plan:
- CHANNELS=4, GATE_CYCLES=100. Ch0 toggles every 5 clks (rising every 10), ch1 idle, ch2 held high, ch3 rises every 25. res_ready=1 -> per window, records chan0..3 = 10, 0, 0, 4; ovf=0; gate_tick every 100 cycles.
- EDGE_MODE=2, ch0 toggling every 5 clks -> count 20. EDGE_MODE=1 -> count 10.
- COUNT_W=4, ch0 rising every 2 clks over a 100-cycle gate -> res_count=15, res_ovf=1. Next window with the input idle -> 0, ovf=0.
- res_ready low for 10 cycles after res_valid -> chan0 record held stable; the first handshake then releases chan1. Total 4 handshakes, records in order.
- res_ready=0 for 150 cycles -> overrun=1 at the second gate_tick. Records restart at chan0 with second-window values. overrun stays 1.
- rst pulled low mid-window with ch0 at count 7 -> all outputs 0 immediately. After release, the first record appears only after a full 100-cycle window.

Source files
------------

// File: rtl/multi_freq_counter.sv
// Multi-channel gated edge counter: counts synchronised pulse edges per gate window,
// snapshots every channel at window end and streams (chan, count, ovf) records out.
module multi_freq_counter #(
    parameter int CHANNELS    = 4,
    parameter int GATE_CYCLES = 100_000_000,
    parameter int COUNT_W     = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    localparam int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [CHANNELS-1:0] pulse_in,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [CHAN_W-1:0]   res_chan,
    output logic [COUNT_W-1:0]  res_count,
    output logic                res_ovf,
    output logic                gate_active,
    output logic                gate_tick,
    output logic                overrun
);
    // state  | meaning
    // S_IDLE | no snapshot pending, res_valid low
    // S_SEND | presenting shadow[ptr], advancing on each handshake

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
    localparam logic [CHAN_W-1:0]  LAST_CHAN = CHAN_W'(CHANNELS - 1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] prev_q;
    logic [CHANNELS-1:0] edge_det;
    logic [GATE_W-1:0]   gate_cnt;
    logic [COUNT_W-1:0]  live_cnt   [CHANNELS];
    logic [COUNT_W-1:0]  live_nxt   [CHANNELS];
    logic [COUNT_W-1:0]  shadow_cnt [CHANNELS];
    logic [CHANNELS-1:0] live_ovf;
    logic [CHANNELS-1:0] ovf_nxt;
    logic [CHANNELS-1:0] shadow_ovf;
    state_t              state;
    logic [CHAN_W-1:0]   ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= pulse_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    if (EDGE_MODE == 1) begin : g_fall
        assign edge_det = ~sync_q[SYNC_STAGES-1] & prev_q;
    end else if (EDGE_MODE == 2) begin : g_both
        assign edge_det = sync_q[SYNC_STAGES-1] ^ prev_q;
    end else begin : g_rise
        assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    assign gate_active = enable & rst;
    assign gate_tick   = gate_active && (gate_cnt == GATE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate_cnt <= '0;
        end else if (!enable || gate_tick) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + 1'b1;
        end
    end

    // Next live value includes this cycle's edge, so the snapshot sees it too.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            live_nxt[i] = live_cnt[i];
            ovf_nxt[i]  = live_ovf[i];
            if (edge_det[i]) begin
                if (live_cnt[i] == COUNT_MAX) ovf_nxt[i] = 1'b1;
                else                          live_nxt[i] = live_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                live_cnt[i]   <= '0;
                shadow_cnt[i] <= '0;
            end
            live_ovf   <= '0;
            shadow_ovf <= '0;
        end else begin
            if (gate_tick) begin
                for (int i = 0; i < CHANNELS; i++) shadow_cnt[i] <= live_nxt[i];
                shadow_ovf <= ovf_nxt;
            end
            if (!enable || gate_tick) begin
                for (int i = 0; i < CHANNELS; i++) live_cnt[i] <= '0;
                live_ovf <= '0;
            end else begin
                for (int i = 0; i < CHANNELS; i++) live_cnt[i] <= live_nxt[i];
                live_ovf <= ovf_nxt;
            end
        end
    end

    // A new snapshot while still sending wins over the pending handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gate_tick) begin
                        state     <= S_SEND;
                        ptr       <= '0;
                        res_valid <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (gate_tick) begin
                        overrun <= 1'b1;
                        ptr     <= '0;
                    end else if (res_ready) begin
                        if (ptr == LAST_CHAN) begin
                            state     <= S_IDLE;
                            res_valid <= 1'b0;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign res_chan  = ptr;
    assign res_count = shadow_cnt[ptr];
    assign res_ovf   = shadow_ovf[ptr];

endmodule

// File: tb/tb_multi_freq_counter.sv
// Three counter variants (rising/4-bit, both/8-bit, falling/8-bit) on shared stimulus,
// checked every cycle against a window-level edge-count model plus literal anchors.
module tb_multi_freq_counter;
    localparam int CH   = 4;
    localparam int GATE = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          res_ready = 1'b0;
    logic [CH-1:0] pulse_in = '0;

    logic       v_a, v_b, v_c, of_a, of_b, of_c, tk_a, tk_b, tk_c;
    logic       ac_a, ac_b, ac_c, ov_a, ov_b, ov_c;
    logic [1:0] ch_a, ch_b, ch_c;
    logic [3:0] cnt_a;
    logic [7:0] cnt_b, cnt_c;

    always #5 clk = ~clk;

    multi_freq_counter #(.CHANNELS(CH), .GATE_CYCLES(GATE), .COUNT_W(4), .SYNC_STAGES(2), .EDGE_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .pulse_in(pulse_in),
        .res_valid(v_a), .res_ready(res_ready), .res_chan(ch_a), .res_count(cnt_a),
        .res_ovf(of_a), .gate_active(ac_a), .gate_tick(tk_a), .overrun(ov_a));

    multi_freq_counter #(.CHANNELS(CH), .GATE_CYCLES(GATE), .COUNT_W(8), .SYNC_STAGES(2), .EDGE_MODE(2)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .pulse_in(pulse_in),
        .res_valid(v_b), .res_ready(res_ready), .res_chan(ch_b), .res_count(cnt_b),
        .res_ovf(of_b), .gate_active(ac_b), .gate_tick(tk_b), .overrun(ov_b));

    multi_freq_counter #(.CHANNELS(CH), .GATE_CYCLES(GATE), .COUNT_W(8), .SYNC_STAGES(2), .EDGE_MODE(1)) dut_c (
        .clk(clk), .rst(rst), .enable(enable), .pulse_in(pulse_in),
        .res_valid(v_c), .res_ready(res_ready), .res_chan(ch_c), .res_count(cnt_c),
        .res_ovf(of_c), .gate_active(ac_c), .gate_tick(tk_c), .overrun(ov_c));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(string name, longint act, longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    endtask

    // Reference model: true edge totals per window, clipped only when reported.
    int     mode_of [3] = '{0, 2, 1};
    longint max_of  [3] = '{15, 255, 255};
    logic [CH-1:0] h0 = '0, h1 = '0, h2 = '0;
    int     gpos = 0;
    longint live_true [3][CH];
    longint snap_cnt  [3][CH];
    bit     snap_ovf  [3][CH];
    int     pend [$];
    bit     m_ovr = 1'b0;

    function automatic bit is_edge(int mode, logic s, logic p);
        case (mode)
            0:       return s && !p;
            1:       return !s && p;
            default: return s != p;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin : model
        bit tick;
        bit busy;
        if (!rst) begin
            h0 = '0; h1 = '0; h2 = '0;
            gpos = 0;
            pend.delete();
            m_ovr = 1'b0;
            for (int m = 0; m < 3; m++)
                for (int c = 0; c < CH; c++) begin
                    live_true[m][c] = 0; snap_cnt[m][c] = 0; snap_ovf[m][c] = 1'b0;
                end
        end else begin
            busy = pend.size() != 0;
            tick = enable && (gpos == GATE - 1);
            if (busy && res_ready) void'(pend.pop_front());
            for (int m = 0; m < 3; m++)
                for (int c = 0; c < CH; c++)
                    if (enable && is_edge(mode_of[m], h1[c], h2[c])) live_true[m][c]++;
            if (tick) begin
                if (busy) m_ovr = 1'b1;
                pend.delete();
                for (int c = 0; c < CH; c++) begin
                    pend.push_back(c);
                    for (int m = 0; m < 3; m++) begin
                        snap_cnt[m][c] = (live_true[m][c] > max_of[m]) ? max_of[m] : live_true[m][c];
                        snap_ovf[m][c] = live_true[m][c] > max_of[m];
                    end
                end
            end
            if (!enable || tick)
                for (int m = 0; m < 3; m++)
                    for (int c = 0; c < CH; c++) live_true[m][c] = 0;
            gpos = (!enable || tick) ? 0 : gpos + 1;
            h2 = h1; h1 = h0; h0 = pulse_in;
        end
    end

    int     hs_cnt = 0;
    int     last_chan = -1;
    longint la_cnt [3][CH];
    bit     la_ovf [3][CH];

    task automatic cmp_dut(string tag, int m, logic v, logic [1:0] chan, longint cnt, logic of,
                           logic tk, logic ac, logic ov, bit ev, int hc);
        chk({tag, ".valid"}, v, ev);
        if (ev) begin
            chk({tag, ".chan"}, chan, hc);
            chk({tag, ".count"}, cnt, snap_cnt[m][hc]);
            chk({tag, ".ovf"}, of, snap_ovf[m][hc]);
        end
        chk({tag, ".gate_tick"}, tk, rst && enable && (gpos == GATE - 1));
        chk({tag, ".gate_active"}, ac, rst && enable);
        chk({tag, ".overrun"}, ov, m_ovr);
    endtask

    always @(negedge clk) begin : compare
        bit ev;
        int hc;
        ev = pend.size() != 0;
        hc = ev ? pend[0] : 0;
        cmp_dut("a", 0, v_a, ch_a, cnt_a, of_a, tk_a, ac_a, ov_a, ev, hc);
        cmp_dut("b", 1, v_b, ch_b, cnt_b, of_b, tk_b, ac_b, ov_b, ev, hc);
        cmp_dut("c", 2, v_c, ch_c, cnt_c, of_c, tk_c, ac_c, ov_c, ev, hc);
        if (v_a && res_ready) begin
            hs_cnt++;
            last_chan = ch_a;
            la_cnt[0][ch_a] = cnt_a; la_ovf[0][ch_a] = of_a;
        end
        if (v_b && res_ready) begin la_cnt[1][ch_b] = cnt_b; la_ovf[1][ch_b] = of_b; end
        if (v_c && res_ready) begin la_cnt[2][ch_c] = cnt_c; la_ovf[2][ch_c] = of_c; end
    end

    int         t = 0;
    int         pat = 0;
    bit         rdy_rand = 1'b0;
    logic [3:0] rnd_p = '0;

    task automatic drive();
        logic [CH-1:0] p;
        p = '0;
        case (pat)
            1: begin
                p[0] = ((t / 5) % 2) == 1;
                p[2] = 1'b1;
                p[3] = (t % 25) < 5;
            end
            2: p[0] = (t < 90) && (t % 2 == 1);
            3: p[0] = ((t / 5) % 2) == 1;
            4: begin
                for (int c = 0; c < CH; c++)
                    if ($urandom_range(0, 3) == 0) rnd_p[c] = ~rnd_p[c];
                p = rnd_p;
            end
            default: p = '0;
        endcase
        pulse_in = p;
        if (rdy_rand) res_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
        drive();
    endtask

    task automatic restart(int p);
        enable = 1'b0;
        pat = 0;
        drive();
        repeat (6) step();
        pat = p;
        t = 0;
        enable = 1'b1;
        drive();
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        int base;
        enable = 1'b1;
        pulse_in = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.valid", v_a, 0);
        chk("reset.count", cnt_a, 0);
        chk("reset.chan", ch_a, 0);
        chk("reset.gate_active", ac_a, 0);
        chk("reset.gate_tick", tk_a, 0);
        chk("reset.overrun", ov_a, 0);
        enable = 1'b0;
        pulse_in = '0;
        rst = 1'b1;
        res_ready = 1'b1;

        // Nominal pattern: ch0 toggling/5, ch1 idle, ch2 high, ch3 rising/25.
        restart(1);
        while (t < 310) begin
            step();
            if (t == 98) chk("tick.before_last", tk_a, 0);
            if (t == 99) chk("tick.last", tk_a, 1);
        end
        chk("nom.rise.ch0", la_cnt[0][0], 10);
        chk("nom.rise.ch1", la_cnt[0][1], 0);
        chk("nom.rise.ch2", la_cnt[0][2], 0);
        chk("nom.rise.ch3", la_cnt[0][3], 4);
        chk("nom.rise.ovf0", la_ovf[0][0], 0);
        chk("nom.both.ch0", la_cnt[1][0], 20);
        chk("nom.fall.ch0", la_cnt[2][0], 10);
        chk("nom.fall.ch3", la_cnt[2][3], 4);

        // Backpressure: hold chan0 for 10 cycles, then drain in order.
        res_ready = 1'b0;
        n = 0;
        while (!v_a && n < 200) begin step(); n++; end
        chk("bp.valid_cycle", t, 400);
        repeat (10) begin
            step();
            chk("bp.hold_chan", ch_a, 0);
            chk("bp.hold_count", cnt_a, 10);
        end
        res_ready = 1'b1;
        base = hs_cnt;
        step();
        chk("bp.release_chan", ch_a, 1);
        repeat (8) step();
        chk("bp.handshakes", hs_cnt - base, 4);
        chk("bp.drained", v_a, 0);

        // Saturation on the 4-bit variant, then an idle window.
        restart(2);
        while (t < 105) step();
        chk("sat.rise.count", la_cnt[0][0], 15);
        chk("sat.rise.ovf", la_ovf[0][0], 1);
        chk("sat.both.count", la_cnt[1][0], 90);
        chk("sat.fall.count", la_cnt[2][0], 45);
        chk("sat.fall.ovf", la_ovf[2][0], 0);
        while (t < 205) step();
        chk("idle.count", la_cnt[0][0], 0);
        chk("idle.ovf", la_ovf[0][0], 0);

        // Overrun: consumer stalled across two window ends.
        restart(3);
        res_ready = 1'b0;
        while (t < 199) step();
        chk("ovr.before_second_tick", ov_a, 0);
        step();
        chk("ovr.set", ov_a, 1);
        while (t < 210) step();
        res_ready = 1'b1;
        base = hs_cnt;
        step();
        chk("ovr.first_hs", hs_cnt - base, 1);
        chk("ovr.restart_chan", last_chan, 0);
        chk("ovr.restart_count", la_cnt[0][0], 10);
        repeat (10) step();
        chk("ovr.sticky", ov_a, 1);

        // Asynchronous reset in the middle of a window.
        restart(3);
        while (t < 73) step();
        rst = 1'b0;
        #1;
        chk("rst.valid", v_a, 0);
        chk("rst.count", cnt_a, 0);
        chk("rst.overrun", ov_a, 0);
        chk("rst.gate_active", ac_a, 0);
        chk("rst.gate_tick", tk_a, 0);
        step();
        step();
        rst = 1'b1;
        n = 0;
        while (!v_a && n < 300) begin step(); n++; end
        chk("rst.first_record_delay", n, 100);

        // Randomised pins, consumer stalls and enable drops.
        pat = 4;
        rdy_rand = 1'b1;
        repeat (2000) begin
            step();
            if ($urandom_range(0, 299) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 20)) step();
                enable = 1'b1;
            end
        end
        rdy_rand = 1'b0;
        res_ready = 1'b1;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
